// File: rtl/mips_mc_core_hs.sv
// Multi-cycle MIPS32 subset core with a req/ready handshake to a unified memory.
// Includes the control FSM, register file, ALU, bus-timeout, illegal-opcode and misalignment traps.
module mips_mc_core_hs #(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          ADDR_W      = 16,
    parameter int          BUS_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [31:0]       pc_dbg
);
    localparam int WC_W = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_BRK   = 6'b001101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_HALT, S_ERR
    } state_t;

    state_t            state_reg;
    logic [31:0]       pc_reg, ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
    logic [31:0]       regs_reg [0:31];
    logic [WC_W-1:0]   wait_cnt_reg;
    logic              halted_reg, halt_done_reg, error_reg;
    logic [1:0]        err_code_reg;

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, rs_val, rt_val, addr_sum, alu_r;
    logic        mem_busy, handshake, timeout;

    assign op       = ir_reg[31:26];
    assign rs       = ir_reg[25:21];
    assign rt       = ir_reg[20:16];
    assign rd       = ir_reg[15:11];
    assign fn       = ir_reg[5:0];
    assign imm_sext = {{16{ir_reg[15]}}, ir_reg[15:0]};
    assign rs_val   = (rs == 5'd0) ? 32'd0 : regs_reg[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : regs_reg[rt];
    assign addr_sum = a_reg + imm_sext;

    always_comb begin
        alu_r = 32'd0;
        case (fn)
            FN_ADD:  alu_r = a_reg + b_reg;
            FN_SUB:  alu_r = a_reg - b_reg;
            FN_AND:  alu_r = a_reg & b_reg;
            FN_OR:   alu_r = a_reg | b_reg;
            FN_SLT:  alu_r = {31'd0, $signed(a_reg) < $signed(b_reg)};
            default: alu_r = 32'd0;
        endcase
    end

    // Request is a pure state decode; gating with reset_n drops it the instant reset asserts.
    assign mem_busy  = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) || (state_reg == S_MEM_WR);
    assign mem_req   = reset_n && mem_busy;
    assign mem_we    = reset_n && (state_reg == S_MEM_WR);
    assign mem_addr  = (state_reg == S_FETCH) ? pc_reg[ADDR_W-1:0] : alu_out_reg[ADDR_W-1:0];
    assign mem_wdata = b_reg;
    assign handshake = mem_req && mem_ready;
    assign timeout   = (BUS_TIMEOUT != 0) && mem_req && !mem_ready
                       && (wait_cnt_reg == WC_W'(BUS_TIMEOUT));

    assign retire = (state_reg == S_WB_R) || (state_reg == S_WB_I) || (state_reg == S_MEM_WB)
                 || (state_reg == S_BRANCH) || (state_reg == S_JUMP)
                 || ((state_reg == S_JR) && (a_reg[1:0] == 2'b00))
                 || ((state_reg == S_MEM_WR) && handshake)
                 || ((state_reg == S_HALT) && !halt_done_reg);
    assign halted   = halted_reg;
    assign error    = error_reg;
    assign err_code = err_code_reg;
    assign pc_dbg   = pc_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_FETCH;
            pc_reg        <= RESET_PC;
            ir_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            alu_out_reg   <= '0;
            mdr_reg       <= '0;
            wait_cnt_reg  <= '0;
            halted_reg    <= 1'b0;
            halt_done_reg <= 1'b0;
            error_reg     <= 1'b0;
            err_code_reg  <= 2'b00;
            for (int i = 0; i < 32; i++) regs_reg[i] <= '0;
        end else begin
            // Any cycle that is not a stalled request restarts the wait count.
            wait_cnt_reg <= (mem_req && !mem_ready) ? wait_cnt_reg + 1'b1 : '0;
            case (state_reg)
                S_FETCH: begin
                    if (handshake) begin
                        ir_reg    <= mem_rdata;
                        pc_reg    <= pc_reg + 32'd4;
                        state_reg <= S_DECODE;
                    end else if (timeout) begin
                        state_reg <= S_ERR; error_reg <= 1'b1; err_code_reg <= 2'b01;
                    end
                end
                S_DECODE: begin
                    a_reg       <= rs_val;
                    b_reg       <= rt_val;
                    alu_out_reg <= pc_reg + {imm_sext[29:0], 2'b00};
                    case (op)
                        OP_RTYPE: begin
                            case (fn)
                                FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_reg <= S_EXEC_R;
                                FN_JR:  state_reg <= S_JR;
                                FN_BRK: begin state_reg <= S_HALT; halted_reg <= 1'b1; end
                                default: begin
                                    state_reg <= S_ERR; error_reg <= 1'b1; err_code_reg <= 2'b10;
                                end
                            endcase
                        end
                        OP_ADDI:      state_reg <= S_EXEC_I;
                        OP_LW, OP_SW: state_reg <= S_MEM_ADDR;
                        OP_BEQ:       state_reg <= S_BRANCH;
                        OP_J:         state_reg <= S_JUMP;
                        default: begin
                            state_reg <= S_ERR; error_reg <= 1'b1; err_code_reg <= 2'b10;
                        end
                    endcase
                end
                S_EXEC_R: begin alu_out_reg <= alu_r;    state_reg <= S_WB_R; end
                S_EXEC_I: begin alu_out_reg <= addr_sum; state_reg <= S_WB_I; end
                S_WB_R: begin
                    if (rd != 5'd0) regs_reg[rd] <= alu_out_reg;
                    state_reg <= S_FETCH;
                end
                S_WB_I: begin
                    if (rt != 5'd0) regs_reg[rt] <= alu_out_reg;
                    state_reg <= S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_out_reg <= addr_sum;
                    if (addr_sum[1:0] != 2'b00) begin
                        state_reg <= S_ERR; error_reg <= 1'b1; err_code_reg <= 2'b11;
                    end else begin
                        state_reg <= (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                    end
                end
                S_MEM_RD: begin
                    if (handshake) begin
                        mdr_reg   <= mem_rdata;
                        state_reg <= S_MEM_WB;
                    end else if (timeout) begin
                        state_reg <= S_ERR; error_reg <= 1'b1; err_code_reg <= 2'b01;
                    end
                end
                S_MEM_WB: begin
                    if (rt != 5'd0) regs_reg[rt] <= mdr_reg;
                    state_reg <= S_FETCH;
                end
                S_MEM_WR: begin
                    if (handshake) begin
                        state_reg <= S_FETCH;
                    end else if (timeout) begin
                        state_reg <= S_ERR; error_reg <= 1'b1; err_code_reg <= 2'b01;
                    end
                end
                S_BRANCH: begin
                    if (a_reg == b_reg) pc_reg <= alu_out_reg;
                    state_reg <= S_FETCH;
                end
                S_JUMP: begin
                    pc_reg    <= {pc_reg[31:28], ir_reg[25:0], 2'b00};
                    state_reg <= S_FETCH;
                end
                S_JR: begin
                    if (a_reg[1:0] != 2'b00) begin
                        state_reg <= S_ERR; error_reg <= 1'b1; err_code_reg <= 2'b11;
                    end else begin
                        pc_reg    <= a_reg;
                        state_reg <= S_FETCH;
                    end
                end
                S_HALT:  halt_done_reg <= 1'b1;
                S_ERR:   state_reg <= S_ERR;
                default: state_reg <= S_ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mc_core_hs.sv
// Directed bench for mips_mc_core_hs: small programs run against a wait-state memory model.
module tb_mips_mc_core_hs;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req, mem_we, mem_ready, retire, halted, error;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata, pc_dbg;
    logic [1:0]  err_code;

    mips_mc_core_hs #(.RESET_PC(32'h100), .ADDR_W(16), .BUS_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .retire(retire), .halted(halted), .error(error),
        .err_code(err_code), .pc_dbg(pc_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND = 6'b100100, OR = 6'b100101;
    localparam logic [5:0] SLT = 6'b101010, JR = 6'b001000;
    localparam logic [31:0] BRK = 32'h0000000D;

    // Program words come from pmem; stores of the current test generation overlay them.
    logic [31:0] pmem [0:255];
    logic [31:0] wmem [0:255];
    int          wgen [0:255];
    int          gen = 0, pp = 0, wait_n = 0;
    bit          never_ready = 1'b0;
    int          cyc = 0, retire_cnt = 0, req_cycles = 0, fetch40 = 0, stab_err = 0, wcnt = 0;
    int          retire_cyc [0:1023];
    int          rc0 = 0, rq0 = 0, f0 = 0;
    int          n_cmp = 0, n_err = 0;

    function automatic logic [31:0] rd_word(input int addr);
        int i = (addr >> 2) & 255;
        return (wgen[i] == gen) ? wmem[i] : pmem[i];
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Memory responder: ready is presented at the falling edge once wait_n cycles have elapsed.
    initial forever begin
        @(negedge clk);
        mem_ready = mem_req && !never_ready && (wcnt >= wait_n);
        mem_rdata = rd_word(int'(mem_addr));
    end

    logic        prev_wait = 1'b0, p_we = 1'b0;
    logic [15:0] p_addr = '0;
    logic [31:0] p_wd = '0;
    initial forever begin
        @(posedge clk);
        cyc++;
        if (retire) begin retire_cyc[retire_cnt & 1023] = cyc; retire_cnt++; end
        if (mem_req) req_cycles++;
        if (prev_wait && mem_req && (mem_addr != p_addr || mem_we != p_we || (p_we && mem_wdata != p_wd)))
            stab_err++;
        prev_wait = mem_req && !mem_ready;
        p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                wmem[int'(mem_addr[9:2])] = mem_wdata;
                wgen[int'(mem_addr[9:2])] = gen;
            end else if (mem_addr == 16'h40) fetch40++;
            wcnt = 0;
        end else if (mem_req) wcnt++;
        else wcnt = 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic emit(input logic [31:0] w);
        pmem[(pp >> 2) & 255] = w;
        pp += 4;
    endtask

    task automatic start_test(input int wn, input bit nr);
        @(posedge clk); #2;
        reset_n = 1'b0;
        wait_n = wn; never_ready = nr; gen++;
        for (int i = 0; i < 256; i++) pmem[i] = 32'd0;
        pp = 'h100;
    endtask

    task automatic release_core();
        repeat (3) @(posedge clk);
        #2; reset_n = 1'b1;
        rc0 = retire_cnt; rq0 = req_cycles; f0 = fetch40;
        #1;
    endtask

    task automatic run_until_stop(input int maxc);
        int n = 0;
        while (!(halted || error) && n < maxc) begin step(); n++; end
        chk("stop_reached", {31'd0, halted | error}, 32'd1);
    endtask

    function automatic logic [31:0] gap(input int k);
        return 32'(retire_cyc[(rc0 + k) & 1023] - retire_cyc[(rc0 + k - 1) & 1023]);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        // T1/T2: reset state and ALU sequence with zero wait states
        start_test(0, 1'b0);
        emit(enc_i(ADDI, 0, 1, 5));   emit(enc_i(ADDI, 0, 2, -3));
        emit(enc_r(1, 2, 3, ADD));    emit(enc_r(2, 1, 4, SLT));
        emit(enc_r(0, 1, 5, SUB));    emit(enc_r(1, 2, 8, AND));
        emit(enc_r(1, 2, 9, OR));     emit(enc_i(ADDI, 0, 0, 7));
        emit(enc_r(1, 2, 10, SLT));
        emit(enc_i(SW, 0, 3, 'h200)); emit(enc_i(SW, 0, 4, 'h204));
        emit(enc_i(SW, 0, 5, 'h208)); emit(enc_i(SW, 0, 8, 'h20C));
        emit(enc_i(SW, 0, 9, 'h210)); emit(enc_i(SW, 0, 0, 'h214));
        emit(enc_i(SW, 0, 10, 'h218)); emit(BRK);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_pc", pc_dbg, 32'h100);
        chk("rst_flags", {28'd0, retire, halted, error, mem_we}, 32'd0);
        release_core();
        chk("rel_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rel_mem_addr", {16'd0, mem_addr}, 32'h100);
        chk("rel_pc", pc_dbg, 32'h100);
        chk("rel_err_code", {30'd0, err_code}, 32'd0);
        run_until_stop(400);
        repeat (5) step();
        chk("t2_add", rd_word('h200), 32'd2);
        chk("t2_slt_signed", rd_word('h204), 32'd1);
        chk("t2_sub", rd_word('h208), 32'hFFFFFFFB);
        chk("t2_and", rd_word('h20C), 32'd5);
        chk("t2_or", rd_word('h210), 32'hFFFFFFFD);
        chk("t2_r0_zero", rd_word('h214), 32'd0);
        chk("t2_slt_false", rd_word('h218), 32'd0);
        for (int k = 1; k < 16; k++) chk($sformatf("t2_gap%0d", k), gap(k), 32'd4);
        chk("t2_break_gap", gap(16), 32'd3);
        chk("t2_retires", 32'(retire_cnt - rc0), 32'd17);
        chk("t2_halted", {31'd0, halted}, 32'd1);
        chk("t2_halt_pc", pc_dbg, 32'h144);
        chk("t2_halt_req", {31'd0, mem_req}, 32'd0);
        $display("T2 alu sequence done, retires=%0d", retire_cnt - rc0);

        // T3: store then load with three wait cycles per transfer
        start_test(3, 1'b0);
        emit(enc_i(ADDI, 0, 1, 5)); emit(enc_i(SW, 0, 1, 8));
        emit(enc_i(LW, 0, 6, 8));   emit(enc_i(SW, 0, 6, 'h220)); emit(BRK);
        release_core();
        run_until_stop(400);
        chk("t3_sw_data", rd_word(8), 32'd5);
        chk("t3_lw_result", rd_word('h220), 32'd5);
        chk("t3_sw_cycles", gap(1), 32'd10);
        chk("t3_lw_cycles", gap(2), 32'd11);
        chk("t3_stable", 32'(stab_err), 32'd0);
        $display("T3 wait-state memory done");

        // T4: beq taken/not taken, j, misaligned jr
        start_test(0, 1'b0);
        emit(enc_i(ADDI, 0, 1, 1));     emit(enc_i(BEQ, 1, 1, 2));
        emit(enc_i(ADDI, 0, 2, 'h11));  emit(enc_i(ADDI, 0, 2, 'h22));
        emit(enc_i(BEQ, 1, 0, 5));      emit(enc_i(ADDI, 0, 3, 'h33));
        emit(enc_i(SW, 0, 2, 'h230));   emit(enc_i(SW, 0, 3, 'h234));
        emit({6'b000010, 26'h10});
        pp = 'h40;
        emit(enc_i(ADDI, 0, 7, 'h202)); emit(enc_i(SW, 0, 7, 'h238)); emit(enc_r(7, 0, 0, JR));
        release_core();
        run_until_stop(400);
        chk("t4_skipped", rd_word('h230), 32'd0);
        chk("t4_fallthrough", rd_word('h234), 32'h33);
        chk("t4_after_jump", rd_word('h238), 32'h202);
        chk("t4_fetch_40", 32'(fetch40 - f0), 32'd1);
        chk("t4_error", {31'd0, error}, 32'd1);
        chk("t4_err_code", {30'd0, err_code}, 32'd3);
        chk("t4_pc_held", pc_dbg, 32'h4C);
        chk("t4_retires", 32'(retire_cnt - rc0), 32'd9);
        $display("T4 control flow done");

        // T5: bus timeout, illegal opcode, misaligned lw, handshake on the timeout cycle
        start_test(0, 1'b1);
        release_core();
        run_until_stop(50);
        chk("t5_timeout_code", {30'd0, err_code}, 32'd1);
        chk("t5_req_cycles", 32'(req_cycles - rq0), 32'd5);
        step();
        chk("t5_req_dropped", {31'd0, mem_req}, 32'd0);
        chk("t5_pc", pc_dbg, 32'h100);

        start_test(0, 1'b0);
        emit(32'hFC000000);
        release_core();
        run_until_stop(50);
        chk("t5_illegal_code", {30'd0, err_code}, 32'd2);
        chk("t5_illegal_pc", pc_dbg, 32'h104);
        chk("t5_illegal_noretire", 32'(retire_cnt - rc0), 32'd0);

        start_test(0, 1'b0);
        emit(enc_i(LW, 0, 1, 2));
        release_core();
        run_until_stop(50);
        chk("t5_misaligned_code", {30'd0, err_code}, 32'd3);

        start_test(4, 1'b0);
        emit(enc_i(ADDI, 0, 1, 5)); emit(enc_i(SW, 0, 1, 'h250));
        emit(enc_i(LW, 0, 2, 'h250)); emit(enc_i(SW, 0, 2, 'h254)); emit(BRK);
        release_core();
        run_until_stop(600);
        chk("t5_edge_noerror", {31'd0, error}, 32'd0);
        chk("t5_edge_result", rd_word('h254), 32'd5);
        $display("T5 error traps done");

        // T6: break alone, then reset during a load wait
        start_test(0, 1'b0);
        emit(BRK);
        release_core();
        run_until_stop(50);
        repeat (10) step();
        chk("t6_halted", {31'd0, halted}, 32'd1);
        chk("t6_single_retire", 32'(retire_cnt - rc0), 32'd1);
        chk("t6_halt_req", {31'd0, mem_req}, 32'd0);
        chk("t6_halt_pc", pc_dbg, 32'h104);

        start_test(3, 1'b0);
        emit(enc_i(SW, 0, 6, 'h240)); emit(enc_i(LW, 0, 6, 8));
        emit(enc_i(SW, 0, 6, 'h244)); emit(BRK);
        pmem[2] = 32'h1234;
        release_core();
        begin
            int n = 0;
            while (!(mem_req && !mem_we && mem_addr == 16'h8) && n < 200) begin step(); n++; end
            chk("t6_lw_reached", {31'd0, mem_req && mem_addr == 16'h8}, 32'd1);
        end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_drop", {31'd0, mem_req}, 32'd0);
        gen++;
        release_core();
        chk("t6_restart_pc", pc_dbg, 32'h100);
        chk("t6_restart_addr", {16'd0, mem_addr}, 32'h100);
        run_until_stop(400);
        chk("t6_reg_cleared", rd_word('h240), 32'd0);
        chk("t6_lw_after", rd_word('h244), 32'h1234);
        chk("t6_clean_halt", {30'd0, halted, error}, 32'd2);
        $display("T6 break and reset-during-wait done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
